// File: rtl/debug_step_ctrl.sv
// Debug step controller: turns UART command bytes into the pipeline advance enable.
// Latency: o_step/o_done are decoded from the state flop; o_report/o_err are registered one-cycle pulses.
// Backpressure: o_cmd_ready is low in STEP and DRAIN; the sender holds its byte until it is accepted.
//
// Ports:
//   clk, rst         - system clock, asynchronous active-low reset
//   i_cmd_valid/i_cmd - command byte from the debug UART receiver
//   i_halt           - HALT opcode in ID this cycle (only looked at in RUN and STEP)
//   o_cmd_ready      - command accepted when i_cmd_valid && o_cmd_ready
//   o_step           - advance enable for every inter-stage latch
//   o_state          - IDLE=0, RUN=1, STEP=2, DRAIN=3, DONE=4
//   o_cycle_count    - saturating count of o_step cycles in this session
//   o_report         - pulse telling the dump unit to send state to the host
//   o_done           - program finished and pipeline drained
//   o_err            - pulse: accepted command is illegal in the current state
module debug_step_ctrl #(
  parameter int          DRAIN_CYCLES = 4,
  parameter int          CNT_W        = 32,
  parameter logic [7:0]  CMD_RUN      = 8'h43,
  parameter logic [7:0]  CMD_STEP     = 8'h53,
  parameter logic [7:0]  CMD_PAUSE    = 8'h50,
  parameter logic [7:0]  CMD_RESET    = 8'h52
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cmd_valid,
  input  logic [7:0]       i_cmd,
  input  logic             i_halt,
  output logic             o_cmd_ready,
  output logic             o_step,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_cycle_count,
  output logic             o_report,
  output logic             o_done,
  output logic             o_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Drain counter must hold DRAIN_CYCLES itself.
  localparam int              DW         = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0]   DRAIN_LOAD = DW'(DRAIN_CYCLES);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cycle_count;
  logic [DW-1:0]      r_drain_cnt;
  logic               r_drain_pend;   // HALT seen while single-stepping, drain not yet finished
  logic               r_report;
  logic               r_err;

  logic               w_step;
  logic               w_cmd_ready;
  logic               w_cmd_acc;
  logic               w_cnt_max;
  logic [DW-1:0]      w_drain_dec;

  // Pure decodes of the state flop so that async reset drops them at once.
  assign w_step      = (r_state == S_RUN) || (r_state == S_STEP) || (r_state == S_DRAIN);
  assign w_cmd_ready = (r_state == S_IDLE) || (r_state == S_RUN) || (r_state == S_DONE);
  assign w_cmd_acc   = i_cmd_valid && w_cmd_ready;
  assign w_cnt_max   = &r_cycle_count;
  // Guarded decrement: never wraps below zero.
  assign w_drain_dec = (r_drain_cnt == '0) ? '0 : r_drain_cnt - DW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_cycle_count <= '0;
      r_drain_cnt   <= '0;
      r_drain_pend  <= 1'b0;
      r_report      <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      // Pulses default low; only a fresh event raises them for one cycle.
      r_report <= 1'b0;
      r_err    <= 1'b0;

      if (w_step && !w_cnt_max) begin
        r_cycle_count <= r_cycle_count + CNT_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (w_cmd_acc) begin
            if (i_cmd == CMD_RUN) begin
              // A pending single-step drain is finished off free-running.
              r_state <= r_drain_pend ? S_DRAIN : S_RUN;
            end else if (i_cmd == CMD_STEP) begin
              r_state <= S_STEP;
            end else if (i_cmd == CMD_RESET) begin
              r_cycle_count <= '0;
              r_drain_cnt   <= '0;
              r_drain_pend  <= 1'b0;
            end else begin
              r_err <= 1'b0 | 1'b1;
            end
          end
        end

        S_RUN: begin
          if (i_halt) begin
            // HALT wins; a command arriving in the same cycle is swallowed.
            r_state     <= S_DRAIN;
            r_drain_cnt <= DRAIN_LOAD;
          end else if (w_cmd_acc) begin
            if (i_cmd == CMD_PAUSE) begin
              r_state <= S_IDLE;
            end else begin
              r_err <= 1'b1;
            end
          end
        end

        S_STEP: begin
          // Every step is reported; if it also finishes the drain, this is the DONE report.
          r_report <= 1'b1;
          if (i_halt && !r_drain_pend) begin
            r_drain_pend <= 1'b1;
            r_drain_cnt  <= DRAIN_LOAD;
            r_state      <= S_IDLE;
          end else if (r_drain_pend) begin
            r_drain_cnt <= w_drain_dec;
            r_state     <= (w_drain_dec == '0) ? S_DONE : S_IDLE;
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_DRAIN: begin
          r_drain_cnt <= w_drain_dec;
          if (r_drain_cnt <= DW'(1)) begin
            r_state  <= S_DONE;
            r_report <= 1'b1;
          end
        end

        S_DONE: begin
          if (w_cmd_acc) begin
            if (i_cmd == CMD_RESET) begin
              r_state       <= S_IDLE;
              r_cycle_count <= '0;
              r_drain_cnt   <= '0;
              r_drain_pend  <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_cmd_ready   = w_cmd_ready;
  assign o_step        = w_step;
  assign o_state       = r_state;
  assign o_cycle_count = r_cycle_count;
  assign o_report      = r_report;
  assign o_done        = (r_state == S_DONE);
  assign o_err         = r_err;

endmodule

// File: tb/tb_debug_step_ctrl.sv
module tb_debug_step_ctrl;

  logic        clk;
  logic        rst;
  logic        i_cmd_valid;
  logic [7:0]  i_cmd;
  logic        i_halt;
  logic        o_cmd_ready;
  logic        o_step;
  logic [2:0]  o_state;
  logic [31:0] o_cycle_count;
  logic        o_report;
  logic        o_done;
  logic        o_err;

  int total = 0;
  int bad   = 0;

  debug_step_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .i_cmd_valid   (i_cmd_valid),
    .i_cmd         (i_cmd),
    .i_halt        (i_halt),
    .o_cmd_ready   (o_cmd_ready),
    .o_step        (o_step),
    .o_state       (o_state),
    .o_cycle_count (o_cycle_count),
    .o_report      (o_report),
    .o_done        (o_done),
    .o_err         (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  // Present a byte for one rising edge; returns on the following falling edge.
  task automatic send(input logic [7:0] c);
    i_cmd_valid = 1'b1;
    i_cmd       = c;
    tick();
    i_cmd_valid = 1'b0;
    i_cmd       = 8'h00;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    total++; if (o_state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", o_state); end
    total++; if (o_step !== 1'b0) begin bad++; $display("FAIL reset_step got=%0b exp=0", o_step); end
    total++; if (o_cycle_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", o_cycle_count); end
    total++; if ({o_report, o_err, o_done} !== 3'b000) begin bad++; $display("FAIL reset_pulses got=%b exp=000", {o_report, o_err, o_done}); end
    total++; if (o_cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", o_cmd_ready); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_step();
    send(8'h53);
    total++; if ({o_state, o_step, o_cmd_ready} !== {3'd2, 1'b1, 1'b0}) begin bad++; $display("FAIL step_in_step got=%b exp=01010", {o_state, o_step, o_cmd_ready}); end
    tick();
    total++; if ({o_state, o_step} !== {3'd0, 1'b0}) begin bad++; $display("FAIL step_after got=%b exp=0000", {o_state, o_step}); end
    total++; if (o_cycle_count !== 32'd1) begin bad++; $display("FAIL step_count got=%0d exp=1", o_cycle_count); end
    total++; if (o_report !== 1'b1) begin bad++; $display("FAIL step_report got=%0b exp=1", o_report); end
    tick();
    total++; if (o_report !== 1'b0) begin bad++; $display("FAIL step_report_clear got=%0b exp=0", o_report); end
    send(8'h52);
    total++; if (o_cycle_count !== 32'd0) begin bad++; $display("FAIL idle_reset_count got=%0d exp=0", o_cycle_count); end
  endtask

  task automatic test_run_halt();
    int steps;
    int reports;
    steps   = 0;
    reports = 0;
    send(8'h43);                 // now in RUN cycle 1
    total++; if (o_state !== 3'd1) begin bad++; $display("FAIL run_state got=%0d exp=1", o_state); end
    repeat (10) tick();          // now in RUN cycle 11
    i_halt = 1'b1;
    tick();
    i_halt = 1'b0;
    total++; if (o_state !== 3'd3) begin bad++; $display("FAIL halt_to_drain got=%0d exp=3", o_state); end
    total++; if (o_cycle_count !== 32'd11) begin bad++; $display("FAIL halt_count got=%0d exp=11", o_cycle_count); end
    for (int i = 0; i < 10; i++) begin
      if (o_step) steps++;
      if (o_report) reports++;
      tick();
    end
    total++; if (steps !== 4) begin bad++; $display("FAIL drain_steps got=%0d exp=4", steps); end
    total++; if (reports !== 1) begin bad++; $display("FAIL drain_reports got=%0d exp=1", reports); end
    total++; if ({o_state, o_done, o_step} !== {3'd4, 1'b1, 1'b0}) begin bad++; $display("FAIL drain_done got=%b exp=10010", {o_state, o_done, o_step}); end
    total++; if (o_cycle_count !== 32'd15) begin bad++; $display("FAIL drain_count got=%0d exp=15", o_cycle_count); end
  endtask

  task automatic test_done_cmds();
    send(8'h43);
    total++; if ({o_err, o_state} !== {1'b1, 3'd4}) begin bad++; $display("FAIL done_run_err got=%b exp=1100", {o_err, o_state}); end
    tick();
    total++; if (o_err !== 1'b0) begin bad++; $display("FAIL done_err_clear got=%0b exp=0", o_err); end
    send(8'h52);
    total++; if ({o_state, o_done} !== {3'd0, 1'b0}) begin bad++; $display("FAIL done_reset got=%b exp=0000", {o_state, o_done}); end
    total++; if (o_cycle_count !== 32'd0) begin bad++; $display("FAIL done_reset_count got=%0d exp=0", o_cycle_count); end
  endtask

  task automatic test_pause();
    send(8'h43);                 // RUN cycle 1
    repeat (4) tick();           // RUN cycle 5
    send(8'h50);
    total++; if ({o_state, o_err} !== {3'd0, 1'b0}) begin bad++; $display("FAIL pause_state got=%b exp=0000", {o_state, o_err}); end
    total++; if (o_cycle_count !== 32'd5) begin bad++; $display("FAIL pause_count got=%0d exp=5", o_cycle_count); end
    send(8'h43);
    tick();
    total++; if (o_cycle_count !== 32'd6) begin bad++; $display("FAIL resume_count got=%0d exp=6", o_cycle_count); end
    send(8'h41);                 // illegal in RUN, stays RUN
    total++; if ({o_err, o_state} !== {1'b1, 3'd1}) begin bad++; $display("FAIL run_bad_cmd got=%b exp=1001", {o_err, o_state}); end
    send(8'h50);
    total++; if ({o_state, o_cycle_count} !== {3'd0, 32'd8}) begin bad++; $display("FAIL resume_pause got=%0d/%0d exp=0/8", o_state, o_cycle_count); end
    send(8'h52);
  endtask

  task automatic test_step_halt();
    i_cmd_valid = 1'b1;
    i_cmd       = 8'h53;
    tick();                      // in STEP
    i_cmd_valid = 1'b0;
    i_halt      = 1'b1;
    tick();
    i_halt      = 1'b0;
    total++; if ({o_state, o_report, o_done} !== {3'd0, 1'b1, 1'b0}) begin bad++; $display("FAIL step_halt got=%b exp=00010", {o_state, o_report, o_done}); end
    for (int k = 1; k <= 3; k++) begin
      send(8'h53);
      tick();
      total++; if ({o_state, o_report} !== {3'd0, 1'b1}) begin bad++; $display("FAIL pend_step%0d got=%b exp=0001", k, {o_state, o_report}); end
    end
    send(8'h53);
    tick();
    total++; if ({o_state, o_done, o_report} !== {3'd4, 1'b1, 1'b1}) begin bad++; $display("FAIL pend_done got=%b exp=10011", {o_state, o_done, o_report}); end
    total++; if (o_cycle_count !== 32'd5) begin bad++; $display("FAIL pend_count got=%0d exp=5", o_cycle_count); end
    tick();
    total++; if (o_report !== 1'b0) begin bad++; $display("FAIL pend_report_clear got=%0b exp=0", o_report); end
    send(8'h52);
  endtask

  task automatic test_idle_err();
    send(8'h41);
    total++; if ({o_err, o_state} !== {1'b1, 3'd0}) begin bad++; $display("FAIL idle_bad_cmd got=%b exp=1000", {o_err, o_state}); end
    send(8'h50);
    total++; if ({o_err, o_state} !== {1'b1, 3'd0}) begin bad++; $display("FAIL idle_pause got=%b exp=1000", {o_err, o_state}); end
    tick();
    total++; if (o_err !== 1'b0) begin bad++; $display("FAIL idle_err_clear got=%0b exp=0", o_err); end
  endtask

  task automatic test_async_reset();
    send(8'h43);
    repeat (3) tick();
    total++; if ({o_step, o_cycle_count} !== {1'b1, 32'd3}) begin bad++; $display("FAIL pre_rst got=%0b/%0d exp=1/3", o_step, o_cycle_count); end
    #2 rst = 1'b0;
    #1;
    total++; if ({o_step, o_state, o_cycle_count} !== {1'b0, 3'd0, 32'd0}) begin bad++; $display("FAIL async_rst got=%0b/%0d/%0d exp=0/0/0", o_step, o_state, o_cycle_count); end
    tick();
    rst = 1'b1;
    tick();
    total++; if (o_state !== 3'd0) begin bad++; $display("FAIL post_rst_state got=%0d exp=0", o_state); end
    send(8'h53);
    total++; if (o_state !== 3'd2) begin bad++; $display("FAIL post_rst_step got=%0d exp=2", o_state); end
    tick();
    total++; if ({o_cycle_count, o_report} !== {32'd1, 1'b1}) begin bad++; $display("FAIL post_rst_count got=%0d/%0b exp=1/1", o_cycle_count, o_report); end
  endtask

  initial begin
    rst         = 1'b0;
    i_cmd_valid = 1'b0;
    i_cmd       = 8'h00;
    i_halt      = 1'b0;
    test_reset();
    test_single_step();
    test_run_halt();
    test_done_cmds();
    test_pause();
    test_step_halt();
    test_idle_err();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/debug_step_ctrl.md
Name: debug_step_ctrl

Overview:
- Generates the per-cycle pipeline advance enable (`o_step`) consumed as `i_step` by every inter-stage latch (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Driven by byte commands from the debug UART receiver. Supports continuous run, single-step, pause and reset-of-session.
- On a HALT detected in ID, drains the remaining pipeline stages, then reports completion to the register/memory dump unit.

Parameters:
- DRAIN_CYCLES, 4, o_step cycles issued after HALT detection to retire in-flight instructions (>=1)
- CNT_W, 32, width of the executed-cycle counter
- CMD_RUN, 8'h43, 'C' continuous run
- CMD_STEP, 8'h53, 'S' single step
- CMD_PAUSE, 8'h50, 'P' pause continuous run
- CMD_RESET, 8'h52, 'R' clear session / leave DONE

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- i_cmd_valid  in  1  command byte valid from UART RX
- i_cmd  in  8  command byte
- i_halt  in  1  HALT opcode present in ID this cycle (meaningful only while o_step=1)
- o_cmd_ready  out  1  command accepted this cycle when i_cmd_valid && o_cmd_ready
- o_step  out  1  pipeline advance enable to all latches
- o_state  out  3  IDLE=0, RUN=1, STEP=2, DRAIN=3, DONE=4
- o_cycle_count  out  CNT_W  number of cycles with o_step=1 this session
- o_report  out  1  one-cycle pulse: dump unit must send state to host
- o_done  out  1  program finished and drained
- o_err  out  1  one-cycle pulse: accepted command illegal in current state

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, o_cycle_count=0, drain counter=0, drain-pending=0, o_report=0, o_err=0. o_step and o_done drop immediately, without waiting for clk.
- o_step = 1 exactly in cycles where state is RUN, STEP or DRAIN. It is decoded from the state register, so no latency beyond the state flop.
- o_cycle_count increments on every o_step=1 cycle and saturates at all-ones.
- o_cmd_ready = 1 in IDLE, RUN, DONE; 0 in STEP, DRAIN. A command not accepted is ignored; the sender holds it.
- Command handling:
  - IDLE:
    - CMD_RUN -> RUN if drain-pending=0, else -> DRAIN with the remaining drain count.
    - CMD_STEP -> STEP.
    - CMD_RESET -> stays IDLE, clears counter and drain-pending.
    - CMD_PAUSE and any other byte -> o_err pulse, no state change.
  - RUN:
    - i_halt=1 -> DRAIN, drain counter loaded with DRAIN_CYCLES. i_halt has priority over a simultaneous command; that command is consumed silently.
    - Otherwise CMD_PAUSE -> IDLE.
    - Any other accepted byte -> o_err pulse, stays RUN.
  - STEP (exactly one cycle):
    - If i_halt=1 and drain-pending=0: set drain-pending, drain counter=DRAIN_CYCLES, -> IDLE.
    - Else if drain-pending=1: decrement drain counter. If the result is 0 -> DONE, else -> IDLE.
    - Else -> IDLE.
    - o_report pulses in the first cycle after STEP.
  - DRAIN: decrement drain counter each cycle. When it was 1 -> DONE. Yields exactly the remaining count of o_step cycles (DRAIN_CYCLES from RUN).
  - DONE:
    - o_done=1.
    - o_report pulses in the first DONE cycle.
    - CMD_RESET -> IDLE, clears counter, drain state, o_done.
    - Any other accepted byte -> o_err pulse.
- i_halt is ignored in IDLE, DRAIN, DONE.
- o_report and o_err are registered one-cycle pulses. They never stay high two consecutive cycles without a new triggering event.
- Reset mid-RUN/DRAIN aborts the session with no report.

Test Plan:
- Reset, send 'S' -> o_step high exactly 1 cycle, o_cycle_count=1, o_report pulse next cycle, o_state=0.
- Send 'C', hold 10 cycles, pulse i_halt on 11th RUN cycle -> 4 further o_step cycles, o_cycle_count=15, o_state=4, o_done=1, single o_report pulse.
- 'C', then 'P' accepted in 5th RUN cycle -> IDLE, o_cycle_count=5; 'C' again -> resumes counting from 5.
- 'S' with i_halt=1 -> IDLE, drain pending. Three 'S' -> IDLE each. Fourth 'S' -> DONE, o_cycle_count=5, o_report per step.
- Byte 8'h41 in IDLE -> o_err 1 cycle, state 0. 'C' in DONE -> o_err, stays 4. 'R' -> o_state=0, o_cycle_count=0, o_done=0.
- rst driven low between clock edges during RUN -> o_step=0 and o_cycle_count=0 before next edge; after release, o_state=0 and 'S' works normally.
